// File: rtl/boss_pathfinder_pkg.sv
// rtl/boss_pathfinder_pkg.sv - shared grid constants, direction codes, FSM/cell types and maze ROM contents
package boss_pathfinder_pkg;

    localparam int GRID_W   = 40;
    localparam int GRID_H   = 40;
    localparam int TILE_PX  = 5;
    localparam int ORIGIN_X = 60;
    localparam int ORIGIN_Y = 30;
    localparam int CELLS    = GRID_W * GRID_H;
    localparam int ADDR_W   = 11;
    localparam int COORD_W  = 6;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_LEFT  = 3'd2,
        DIR_DOWN  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_CLEAR,
        ST_SEED,
        ST_POP,
        ST_NBR_RD,
        ST_NBR_EV,
        ST_FIN
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
    } cell_t;

    // The boss moves back along the edge the search used to reach it.
    function automatic dir_t opposite_dir(input dir_t d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return DIR_NONE;
        endcase
    endfunction

    // Standard maze: solid border, pillar lattice, two short wall segments.
    function automatic logic maze_wall(input int row, input int col);
        if (row <= 0 || col <= 0 || row >= GRID_H - 1 || col >= GRID_W - 1) return 1'b1;
        if ((row % 4 == 0) && (col % 4 == 0)) return 1'b1;
        if (row == 20 && col >= 10 && col <= 14) return 1'b1;
        if (col == 26 && row >= 6 && row <= 12) return 1'b1;
        return 1'b0;
    endfunction

endpackage

// File: rtl/boss_pathfinder_if.sv
// rtl/boss_pathfinder_if.sv - request/response and maze ROM signals of the boss pathfinder
interface boss_pathfinder_if;

    logic        start;
    logic [5:0]  player_tx;
    logic [5:0]  player_ty;
    logic [5:0]  boss_tx;
    logic [5:0]  boss_ty;
    logic [10:0] wall_addr;
    logic        wall_in;
    logic        busy;
    logic        done;
    logic        found;
    logic [2:0]  dir;

    modport slave (
        input  start, player_tx, player_ty, boss_tx, boss_ty, wall_in,
        output wall_addr, busy, done, found, dir
    );

    modport master (
        output start, player_tx, player_ty, boss_tx, boss_ty, wall_in,
        input  wall_addr, busy, done, found, dir
    );

endinterface

// File: rtl/boss_pathfinder_bfs_ram.sv
// rtl/boss_pathfinder_bfs_ram.sv - simple dual-port synchronous RAM with 1-cycle read latency
module boss_pathfinder_bfs_ram #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1600,
    parameter int AW    = 11
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // rdata holds its value while re is low, so a popped word stays usable.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/boss_pathfinder.sv
// rtl/boss_pathfinder.sv - BFS from player to boss returning the boss's first step
// Optional feature macro PATHFINDER_STATS_EN adds search_cycles/nodes_pushed outputs.
module boss_pathfinder #(
    parameter int GRID_W     = 40,
    parameter int GRID_H     = 40,
    parameter int MAX_CYCLES = 16000
) (
    input  logic clk,
    input  logic rst,
    boss_pathfinder_if.slave ifc
`ifdef PATHFINDER_STATS_EN
    ,
    output logic [15:0] search_cycles,
    output logic [10:0] nodes_pushed
`endif
);
    import boss_pathfinder_pkg::*;

    localparam int NCELLS = GRID_W * GRID_H;
    localparam int WD_W   = $clog2(MAX_CYCLES + 1);

    state_t          state, state_nxt;
    cell_t           player_q, boss_q, nbr, q_wdata, q_rdata;
    logic [10:0]     head, tail, clr_addr, nbr_addr, player_addr;
    logic [10:0]     vis_waddr, vis_raddr, q_waddr, q_raddr;
    logic [1:0]      nbr_idx;
    logic [WD_W-1:0] wd_cnt;
    logic            nbr_in_grid, push, busy_st;
    logic            found_q, found_nxt;
    dir_t            dir_q, dir_nxt, nbr_code;
    logic            vis_we, vis_wdata, vis_re, vis_rdata, q_we, q_re;

    boss_pathfinder_bfs_ram #(.WIDTH(1), .DEPTH(NCELLS), .AW(11)) u_visited (
        .clk(clk), .we(vis_we), .waddr(vis_waddr), .wdata(vis_wdata),
        .re(vis_re), .raddr(vis_raddr), .rdata(vis_rdata)
    );

    boss_pathfinder_bfs_ram #(.WIDTH(12), .DEPTH(NCELLS), .AW(11)) u_queue (
        .clk(clk), .we(q_we), .waddr(q_waddr), .wdata(q_wdata),
        .re(q_re), .raddr(q_raddr), .rdata(q_rdata)
    );

    // Neighbour of the popped cell selected by nbr_idx (0..3 = UP, LEFT, DOWN, RIGHT).
    always_comb begin
        nbr         = q_rdata;
        nbr_in_grid = 1'b0;
        case (nbr_idx)
            2'd0: begin
                nbr.row     = q_rdata.row - 6'd1;
                nbr_in_grid = (q_rdata.row != 6'd0);
            end
            2'd1: begin
                nbr.col     = q_rdata.col - 6'd1;
                nbr_in_grid = (q_rdata.col != 6'd0);
            end
            2'd2: begin
                nbr.row     = q_rdata.row + 6'd1;
                nbr_in_grid = (q_rdata.row != 6'(GRID_H - 1));
            end
            default: begin
                nbr.col     = q_rdata.col + 6'd1;
                nbr_in_grid = (q_rdata.col != 6'(GRID_W - 1));
            end
        endcase
    end

    assign nbr_addr    = 11'(nbr.row * GRID_W + nbr.col);
    assign player_addr = 11'(player_q.row * GRID_W + player_q.col);
    assign nbr_code    = dir_t'(3'({1'b0, nbr_idx}) + 3'd1);
    assign push        = (state == ST_NBR_EV) && !ifc.wall_in && !vis_rdata;
    assign busy_st     = (state != ST_IDLE) && (state != ST_FIN);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        found_nxt = 1'b0;
        dir_nxt   = DIR_NONE;
        case (state)
            ST_IDLE:  if (ifc.start) state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (boss_q == player_q) begin
                    state_nxt = ST_FIN;
                    found_nxt = 1'b1;
                end else begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: if (clr_addr == 11'(NCELLS - 1)) state_nxt = ST_SEED;
            ST_SEED:  state_nxt = ST_POP;
            ST_POP:   state_nxt = (head == tail) ? ST_FIN : ST_NBR_RD;
            ST_NBR_RD: begin
                if (nbr_in_grid)          state_nxt = ST_NBR_EV;
                else if (nbr_idx == 2'd3) state_nxt = ST_POP;
            end
            ST_NBR_EV: begin
                if (push && (nbr == boss_q)) begin
                    state_nxt = ST_FIN;
                    found_nxt = 1'b1;
                    dir_nxt   = opposite_dir(nbr_code);
                end else if (nbr_idx == 2'd3) begin
                    state_nxt = ST_POP;
                end else begin
                    state_nxt = ST_NBR_RD;
                end
            end
            ST_FIN:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        // Watchdog overrides any result found in the same cycle.
        if (busy_st && (wd_cnt == WD_W'(MAX_CYCLES - 1))) begin
            state_nxt = ST_FIN;
            found_nxt = 1'b0;
            dir_nxt   = DIR_NONE;
        end
    end

    always_comb begin
        ifc.busy      = busy_st;
        ifc.done      = (state == ST_FIN);
        ifc.wall_addr = 11'd0;
        vis_we        = 1'b0;
        vis_waddr     = clr_addr;
        vis_wdata     = 1'b0;
        vis_re        = 1'b0;
        vis_raddr     = nbr_addr;
        q_we          = 1'b0;
        q_waddr       = tail;
        q_wdata       = nbr;
        q_re          = 1'b0;
        q_raddr       = head;
        case (state)
            ST_CLEAR: vis_we = 1'b1;
            ST_SEED: begin
                vis_we    = 1'b1;
                vis_waddr = player_addr;
                vis_wdata = 1'b1;
                q_we      = 1'b1;
                q_wdata   = player_q;
            end
            ST_POP: q_re = (head != tail);
            ST_NBR_RD: begin
                if (nbr_in_grid) begin
                    vis_re        = 1'b1;
                    ifc.wall_addr = nbr_addr;
                end
            end
            ST_NBR_EV: begin
                if (push) begin
                    vis_we    = 1'b1;
                    vis_waddr = nbr_addr;
                    vis_wdata = 1'b1;
                    q_we      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            player_q <= '0;
            boss_q   <= '0;
            head     <= 11'd0;
            tail     <= 11'd0;
            clr_addr <= 11'd0;
            nbr_idx  <= 2'd0;
            wd_cnt   <= '0;
            found_q  <= 1'b0;
            dir_q    <= DIR_NONE;
        end else begin
            if (state == ST_IDLE && ifc.start) begin
                player_q <= '{row: ifc.player_ty, col: ifc.player_tx};
                boss_q   <= '{row: ifc.boss_ty,   col: ifc.boss_tx};
                head     <= 11'd0;
                tail     <= 11'd0;
                clr_addr <= 11'd0;
                wd_cnt   <= '0;
            end
            if (busy_st) wd_cnt <= wd_cnt + 1'b1;
            if (state == ST_CLEAR) clr_addr <= clr_addr + 11'd1;
            if (state == ST_SEED) tail <= 11'd1;
            if (state == ST_POP) begin
                nbr_idx <= 2'd0;
                if (head != tail) head <= head + 11'd1;
            end
            if (state == ST_NBR_RD && !nbr_in_grid) nbr_idx <= nbr_idx + 2'd1;
            if (state == ST_NBR_EV) begin
                nbr_idx <= nbr_idx + 2'd1;
                if (push) tail <= tail + 11'd1;
            end
            if (state_nxt == ST_FIN && state != ST_FIN) begin
                found_q <= found_nxt;
                dir_q   <= dir_nxt;
            end
        end
    end

    assign ifc.found = found_q;
    assign ifc.dir   = dir_q;

`ifdef PATHFINDER_STATS_EN
    // In FIN wd_cnt equals the busy cycles; +1 covers the edge that raises done.
    always_ff @(posedge clk) begin
        if (rst) begin
            search_cycles <= 16'd0;
            nodes_pushed  <= 11'd0;
        end else if (state == ST_FIN) begin
            search_cycles <= 16'(wd_cnt) + 16'd1;
            nodes_pushed  <= tail;
        end
    end
`endif

endmodule

// File: tb/tb_boss_pathfinder.sv
// tb/tb_boss_pathfinder.sv - scoreboard bench with a queue-based BFS reference model
module tb_boss_pathfinder;
    import boss_pathfinder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    boss_pathfinder_if ifc ();
    boss_pathfinder_if ifw ();

`ifdef PATHFINDER_STATS_EN
    logic [15:0] sc_m, sc_w;
    logic [10:0] np_m, np_w;
`endif

    boss_pathfinder dut (
        .clk(clk), .rst(rst), .ifc(ifc.slave)
`ifdef PATHFINDER_STATS_EN
        , .search_cycles(sc_m), .nodes_pushed(np_m)
`endif
    );

    boss_pathfinder #(.MAX_CYCLES(100)) dut_wd (
        .clk(clk), .rst(rst), .ifc(ifw.slave)
`ifdef PATHFINDER_STATS_EN
        , .search_cycles(sc_w), .nodes_pushed(np_w)
`endif
    );

    always @(posedge clk) begin
        ifc.wall_in <= maze_wall(int'(ifc.wall_addr) / GRID_W, int'(ifc.wall_addr) % GRID_W);
        ifw.wall_in <= maze_wall(int'(ifw.wall_addr) / GRID_W, int'(ifw.wall_addr) % GRID_W);
    end

    typedef struct {
        bit    f;
        int    d;
        string name;
    } exp_t;

    exp_t exp_main[$];
    exp_t exp_wd[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endfunction

    // Reference: plain BFS from the player; first discovery of the boss decides.
    function automatic void ref_bfs(input int ptx, input int pty, input int btx, input int bty,
                                    output bit f, output int d);
        bit seen [GRID_H][GRID_W];
        int qr[$];
        int qc[$];
        int dr[4] = '{-1, 0, 1, 0};
        int dc[4] = '{0, -1, 0, 1};
        int r, c, nr, nc;
        f = 1'b0;
        d = 0;
        if (ptx == btx && pty == bty) begin
            f = 1'b1;
            return;
        end
        seen = '{default: 1'b0};
        seen[pty][ptx] = 1'b1;
        qr.push_back(pty);
        qc.push_back(ptx);
        while (qr.size() > 0) begin
            r = qr.pop_front();
            c = qc.pop_front();
            for (int k = 0; k < 4; k++) begin
                nr = r + dr[k];
                nc = c + dc[k];
                if (nr < 0 || nc < 0 || nr >= GRID_H || nc >= GRID_W) continue;
                if (maze_wall(nr, nc) || seen[nr][nc]) continue;
                seen[nr][nc] = 1'b1;
                qr.push_back(nr);
                qc.push_back(nc);
                if (nr == bty && nc == btx) begin
                    f = 1'b1;
                    d = ((k + 2) % 4) + 1;
                    return;
                end
            end
        end
    endfunction

    function automatic int o_busy(input bit w);  return w ? int'(ifw.busy)      : int'(ifc.busy);      endfunction
    function automatic int o_done(input bit w);  return w ? int'(ifw.done)      : int'(ifc.done);      endfunction
    function automatic int o_found(input bit w); return w ? int'(ifw.found)     : int'(ifc.found);     endfunction
    function automatic int o_dir(input bit w);   return w ? int'(ifw.dir)       : int'(ifc.dir);       endfunction
    function automatic int o_waddr(input bit w); return w ? int'(ifw.wall_addr) : int'(ifc.wall_addr); endfunction

    task automatic check_out(input bit w);
        exp_t e;
        if ((w && exp_wd.size() == 0) || (!w && exp_main.size() == 0)) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done dut_wd=%0d: got done with found=%0d dir=%0d, required no done",
                     w, o_found(w), o_dir(w));
            return;
        end
        if (w) e = exp_wd.pop_front();
        else   e = exp_main.pop_front();
        chk({e.name, " found"}, o_found(w), int'(e.f));
        chk({e.name, " dir"}, o_dir(w), e.d);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && ifc.done === 1'b1) check_out(1'b0);
        if (rst === 1'b0 && ifw.done === 1'b1) check_out(1'b1);
    end

    task automatic push_exp(input bit w, input bit f, input int d, input string name);
        exp_t e;
        e.f = f;
        e.d = d;
        e.name = name;
        if (w) exp_wd.push_back(e);
        else   exp_main.push_back(e);
    endtask

    task automatic drive(input bit w, input int ptx, input int pty, input int btx, input int bty, input bit st);
        if (w) begin
            ifw.player_tx = 6'(ptx); ifw.player_ty = 6'(pty);
            ifw.boss_tx   = 6'(btx); ifw.boss_ty   = 6'(bty);
            ifw.start     = st;
        end else begin
            ifc.player_tx = 6'(ptx); ifc.player_ty = 6'(pty);
            ifc.boss_tx   = 6'(btx); ifc.boss_ty   = 6'(bty);
            ifc.start     = st;
        end
    endtask

    task automatic drop_start(input bit w);
        if (w) ifw.start = 1'b0;
        else   ifc.start = 1'b0;
    endtask

    task automatic run_req(input bit w, input int ptx, input int pty, input int btx, input int bty,
                           input int glitch_at, input int rst_at, output int busy_n, output int lat);
        bit got;
        int limit;
        got    = 1'b0;
        busy_n = 0;
        lat    = 0;
        limit  = w ? 400 : 20000;
        @(posedge clk); #1;
        drive(w, ptx, pty, btx, bty, 1'b1);
        @(posedge clk); #1;
        drop_start(w);
        for (int k = 1; k <= limit && !got; k++) begin
            @(negedge clk);
            lat = k;
            if (k == rst_at) begin
                rst = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    chk("rst busy", o_busy(w), 0);
                    chk("rst done", o_done(w), 0);
                end
                chk("rst found", o_found(w), 0);
                chk("rst dir", o_dir(w), 0);
                rst = 1'b0;
                if (w) exp_wd.delete();
                else   exp_main.delete();
                return;
            end
            if (k == glitch_at) drive(w, 3, 7, 9, 9, 1'b1);
            else if (k == glitch_at + 1) drop_start(w);
            if (o_busy(w) != 0) busy_n++;
            if (o_done(w) != 0) got = 1'b1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL timeout dut_wd=%0d: got no done in %0d cycles, required done", w, limit);
        end else begin
            @(negedge clk);
            chk("done one-cycle pulse", o_done(w), 0);
        end
    endtask

    int  bn, lat, pr, pc, br, bc, ed, tries;
    bit  ef;

    initial begin
        rst = 1'b1;
        drive(1'b0, 0, 0, 0, 0, 1'b0);
        drive(1'b1, 0, 0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            chk("reset busy", o_busy(w[0]), 0);
            chk("reset done", o_done(w[0]), 0);
            chk("reset found", o_found(w[0]), 0);
            chk("reset dir", o_dir(w[0]), 0);
            chk("reset wall_addr", o_waddr(w[0]), 0);
        end
        rst = 1'b0;

        push_exp(1'b0, 1'b1, 0, "same tile");
        run_req(1'b0, 5, 5, 5, 5, 0, 0, bn, lat);
        chk("same tile latency", lat, 2);
        chk("same tile busy cycles", bn, 1);

        push_exp(1'b0, 1'b1, 2, "boss right of player");
        run_req(1'b0, 1, 1, 3, 1, 0, 0, bn, lat);

        push_exp(1'b0, 1'b1, 1, "boss below player with start glitch");
        run_req(1'b0, 1, 1, 1, 3, 50, 0, bn, lat);

        push_exp(1'b0, 1'b0, 0, "boss on wall");
        run_req(1'b0, 1, 1, 0, 0, 0, 0, bn, lat);

        push_exp(1'b1, 1'b0, 0, "watchdog abort");
        run_req(1'b1, 1, 1, 38, 38, 0, 0, bn, lat);
        chk("watchdog busy cycles", bn, 100);

        push_exp(1'b0, 1'b1, 2, "aborted by rst");
        run_req(1'b0, 1, 1, 3, 1, 0, 500, bn, lat);
        push_exp(1'b0, 1'b1, 2, "rerun after rst");
        run_req(1'b0, 1, 1, 3, 1, 0, 0, bn, lat);

        for (int i = 0; i < 8; i++) begin
            do begin
                pr = int'($urandom_range(38, 1));
                pc = int'($urandom_range(38, 1));
            end while (maze_wall(pr, pc));
            tries = 0;
            do begin
                br = pr + int'($urandom_range(8, 0)) - 4;
                bc = pc + int'($urandom_range(8, 0)) - 4;
                if (br < 1) br = 1;
                if (br > 38) br = 38;
                if (bc < 1) bc = 1;
                if (bc > 38) bc = 38;
                tries++;
                if (tries > 50) begin br = pr; bc = pc; end
            end while (maze_wall(br, bc));
            ref_bfs(pc, pr, bc, br, ef, ed);
            push_exp(1'b0, ef, ed, $sformatf("random%0d p=(%0d,%0d) b=(%0d,%0d)", i, pc, pr, bc, br));
            run_req(1'b0, pc, pr, bc, br, 0, 0, bn, lat);
        end

        for (int i = 0; i < 4; i++) begin
            pc = int'($urandom_range(38, 1));
            pr = int'($urandom_range(38, 1));
            bc = (i % 2 == 0) ? pc : int'($urandom_range(38, 1));
            br = (i % 2 == 0) ? pr : int'($urandom_range(38, 1));
            push_exp(1'b1, (pc == bc) && (pr == br), 0, $sformatf("wd random%0d", i));
            run_req(1'b1, pc, pr, bc, br, 0, 0, bn, lat);
        end

        repeat (5) @(negedge clk);
        chk("main scoreboard drained", exp_main.size(), 0);
        chk("wd scoreboard drained", exp_wd.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
